// File: rtl/misc_v_pkg.sv
// Shared constants and types for the instruction-fetch / load-store memory arbiter.
package misc_v_pkg;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned ADDR_W     = 16;
  localparam int unsigned STARVE_MAX = 3;
  localparam int unsigned RD_LATENCY = 3;

  typedef enum logic {
    OwnerIf = 1'b0,
    OwnerLs = 1'b1
  } owner_e;

  // Counter width able to hold 0..max_val, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Client ports (fetch, load/store) and single-port memory drive of the arbiter.
interface mem_arbiter_if #(
  parameter int unsigned DATA_W = misc_v_pkg::DATA_W,
  parameter int unsigned ADDR_W = misc_v_pkg::ADDR_W
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              ls_req;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic              ls_gnt;
  logic              ls_rvalid;
  logic [DATA_W-1:0] ls_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_w;
  logic              mem_r;
  logic [DATA_W-1:0] mem_q;

  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_q,
    output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
           mem_addr, mem_data, mem_w, mem_r
  );

  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_q,
    input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
           mem_addr, mem_data, mem_w, mem_r
  );

endinterface

// File: rtl/mem_rd_pipe.sv
// Carries valid + owner tag of each granted read until memory data is ready to capture.
module mem_rd_pipe
  import misc_v_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   rd_valid_i,
  input  owner_e owner_i,
  output logic   cap_if_o,
  output logic   cap_ls_o
);

  // Last stage lines up with mem_q; the capture register adds the final cycle.
  localparam int unsigned Stages = RD_LATENCY - 1;

  logic [Stages-1:0] valid_q, valid_d;
  logic [Stages-1:0] owner_q, owner_d;

  always_comb begin
    valid_d    = '0;
    owner_d    = '0;
    valid_d[0] = rd_valid_i;
    owner_d[0] = owner_i;
    for (int unsigned i = 1; i < Stages; i++) begin
      valid_d[i] = valid_q[i-1];
      owner_d[i] = owner_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      owner_q <= '0;
    end else begin
      valid_q <= valid_d;
      owner_q <= owner_d;
    end
  end

  assign cap_if_o = valid_q[Stages-1] && (owner_q[Stages-1] == OwnerIf);
  assign cap_ls_o = valid_q[Stages-1] && (owner_q[Stages-1] == OwnerLs);

endmodule

// File: rtl/mem_arbiter.sv
// Two-client single-port memory arbiter: load/store priority with bounded fetch starvation.
module mem_arbiter #(
  parameter int unsigned DATA_W     = misc_v_pkg::DATA_W,
  parameter int unsigned ADDR_W     = misc_v_pkg::ADDR_W,
  parameter int unsigned STARVE_MAX = misc_v_pkg::STARVE_MAX
) (
  input logic           clk,
  input logic           rst,
  mem_arbiter_if.slave  bus_io
);
  import misc_v_pkg::*;

  localparam int unsigned     CntW      = cnt_width(STARVE_MAX);
  localparam logic [CntW-1:0] StarveLim = CntW'(STARVE_MAX);

  logic              if_gnt, ls_gnt;
  logic [CntW-1:0]   starve_cnt_q, starve_cnt_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic              mem_w_q, mem_w_d, mem_r_q, mem_r_d;
  logic              if_rvalid_q, ls_rvalid_q;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d, ls_rdata_q, ls_rdata_d;
  logic              cap_if, cap_ls;
  owner_e            rd_owner;

  always_comb begin
    if_gnt = 1'b0;
    ls_gnt = 1'b0;
    if (!rst) begin
      if (bus_io.if_req && bus_io.ls_req) begin
        if (starve_cnt_q == StarveLim) if_gnt = 1'b1;
        else                           ls_gnt = 1'b1;
      end else begin
        if_gnt = bus_io.if_req;
        ls_gnt = bus_io.ls_req;
      end
    end
  end

  // Fetch losing to load/store is the only way the count grows.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!bus_io.if_req || if_gnt) begin
      starve_cnt_d = '0;
    end else if (ls_gnt && (starve_cnt_q != StarveLim)) begin
      starve_cnt_d = starve_cnt_q + CntW'(1);
    end
  end

  always_comb begin
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    mem_w_d    = 1'b0;
    mem_r_d    = 1'b0;
    if (ls_gnt) begin
      mem_addr_d = bus_io.ls_addr;
      mem_data_d = bus_io.ls_we ? bus_io.ls_wdata : '0;
      mem_w_d    = bus_io.ls_we;
      mem_r_d    = !bus_io.ls_we;
    end else if (if_gnt) begin
      mem_addr_d = bus_io.if_addr;
      mem_data_d = '0;
      mem_r_d    = 1'b1;
    end
  end

  assign rd_owner = ls_gnt ? OwnerLs : OwnerIf;

  mem_rd_pipe u_rd_pipe (
    .clk_i      (clk),
    .rst_i      (rst),
    .rd_valid_i (mem_r_d),
    .owner_i    (rd_owner),
    .cap_if_o   (cap_if),
    .cap_ls_o   (cap_ls)
  );

  assign if_rdata_d = cap_if ? bus_io.mem_q : if_rdata_q;
  assign ls_rdata_d = cap_ls ? bus_io.mem_q : ls_rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q <= '0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      mem_w_q      <= 1'b0;
      mem_r_q      <= 1'b0;
      if_rvalid_q  <= 1'b0;
      ls_rvalid_q  <= 1'b0;
      if_rdata_q   <= '0;
      ls_rdata_q   <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      mem_w_q      <= mem_w_d;
      mem_r_q      <= mem_r_d;
      if_rvalid_q  <= cap_if;
      ls_rvalid_q  <= cap_ls;
      if_rdata_q   <= if_rdata_d;
      ls_rdata_q   <= ls_rdata_d;
    end
  end

  assign bus_io.if_gnt    = if_gnt;
  assign bus_io.ls_gnt    = ls_gnt;
  assign bus_io.if_rvalid = if_rvalid_q;
  assign bus_io.ls_rvalid = ls_rvalid_q;
  assign bus_io.if_rdata  = if_rdata_q;
  assign bus_io.ls_rdata  = ls_rdata_q;
  assign bus_io.mem_addr  = mem_addr_q;
  assign bus_io.mem_data  = mem_data_q;
  assign bus_io.mem_w     = mem_w_q;
  assign bus_io.mem_r     = mem_r_q;

endmodule
